// File: rtl/arm_mem_pkg.sv
// Shared memory-stage types and constants for the off-chip SRAM path.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

  localparam int unsigned SRAM_BASE_ADDR = 1024;
  localparam int unsigned SRAM_DW        = 16;
endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request/response and SRAM pin bundle; slave is the controller, master the environment.
interface sram_controller_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic                             rd_en;
  logic                             wr_en;
  logic [31:0]                      address;
  logic [31:0]                      write_data;
  logic [31:0]                      read_data;
  logic                             ready;
  logic [SRAM_AW-1:0]               sram_addr;
  logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_o;
  logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_i;
  logic                             sram_dq_oe;
  logic                             sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_i,
    input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_i,
    output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_phase_timer.sv
// Phase cycle counter: restart loads 0, then counts up and holds at terminal count.
// last_cycle is combinational from the count, so it is valid in the same cycle the count reaches PHASE_CYCLES-1.
module sram_phase_timer #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic last_cycle
);
  logic [3:0] cnt_q, cnt_d;

  assign last_cycle = (cnt_q == 4'(PHASE_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (!last_cycle) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two timed 16-bit SRAM accesses; ready is low until DONE (2*PHASE_CYCLES+1 cycles).
// SRAM_READ_CACHE_EN adds a one-entry read cache so a repeated load finishes in one cycle.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned BASE_ADDR    = SRAM_BASE_ADDR,
  parameter int unsigned SRAM_AW      = 18
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus
);
  localparam int unsigned WW = SRAM_AW - 1;

  sram_state_t   state_q, state_d;
  logic [WW-1:0] addr_word_q, addr_word_d, req_word;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [31:0]   req_off;
  logic          is_write_q, is_write_d;
  logic          req_vld, last_cycle, timer_restart, in_phase, ready_c;
  logic          unused_addr_bits;

  assign req_vld          = bus.rd_en | bus.wr_en;
  assign req_off          = bus.address - BASE_ADDR;
  assign req_word         = req_off[WW+1:2];
  assign unused_addr_bits = ^{req_off[31:WW+2], req_off[1:0]};

`ifdef SRAM_READ_CACHE_EN
  logic          cache_vld_q, cache_vld_d;
  logic [WW-1:0] cache_word_q, cache_word_d;
  logic [31:0]   cache_data_q, cache_data_d;
  logic          cache_hit;

  assign cache_hit = bus.rd_en & ~bus.wr_en & cache_vld_q & (cache_word_q == req_word);
`endif

  sram_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (timer_restart),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_d     = state_q;
    addr_word_d = addr_word_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    ready_c     = 1'b0;
`ifdef SRAM_READ_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_word_d = cache_word_q;
    cache_data_d = cache_data_q;
`endif
    case (state_q)
      IDLE: begin
        ready_c = ~req_vld;
        if (req_vld) begin
          addr_word_d = req_word;
          wdata_d     = bus.write_data;
          is_write_d  = bus.wr_en;
          state_d     = LO;
`ifdef SRAM_READ_CACHE_EN
          if (cache_hit) begin
            state_d     = DONE;
            read_data_d = cache_data_q;
          end
`endif
        end
      end
      LO: begin
        if (last_cycle) begin
          state_d = HI;
          if (!is_write_q) read_data_d[15:0] = bus.sram_dq_i;
        end
      end
      HI: begin
        if (last_cycle) begin
          state_d = DONE;
          if (!is_write_q) read_data_d[31:16] = bus.sram_dq_i;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
`ifdef SRAM_READ_CACHE_EN
        if (!is_write_q) begin
          cache_vld_d  = 1'b1;
          cache_word_d = addr_word_q;
          cache_data_d = read_data_q;
        end else if (cache_vld_q && cache_word_q == addr_word_q) begin
          cache_data_d = wdata_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    timer_restart = (state_d != state_q) && (state_d == LO || state_d == HI);
  end

  // Strobe drops on the last phase cycle so the address is stable across the whole write pulse.
  assign in_phase       = (state_q == LO) || (state_q == HI);
  assign bus.ready      = ready_c;
  assign bus.read_data  = read_data_q;
  assign bus.sram_addr  = {addr_word_q, state_q == HI};
  assign bus.sram_dq_oe = is_write_q & in_phase;
  assign bus.sram_dq_o  = !(is_write_q && in_phase) ? '0 :
                          (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign bus.sram_we_n  = ~(is_write_q & in_phase & ~last_cycle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_word_q <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_word_q <= addr_word_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef SRAM_READ_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_word_q <= '0;
      cache_data_q <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_word_q <= cache_word_d;
      cache_data_q <= cache_data_d;
    end
  end
`endif
endmodule
